// File: rtl/uart_rx_if.sv
// Output side of uart_rx: a one-entry valid/ready word register plus framing/overrun pulses.
// The receiver drives the master modport; the consumer of received words uses the slave modport.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  frame_err;
    logic                  overrun;

    modport master (
        output data,
        output valid,
        output frame_err,
        output overrun,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  frame_err,
        input  overrun,
        output ready
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop line synchronizer, mid-bit sampling, start/stop validation,
// one-entry valid/ready output register, and single-cycle framing-error and overrun pulses.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 115200,
    parameter int CLK_FREQ   = 100_000_000
) (
    input  logic      clk,
    input  logic      rstn,
    input  logic      rx_sig,
    uart_rx_if.master rx_out
);
    localparam int PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
    localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
    localparam int CNT_W            = $clog2(PULSE_WIDTH) + 1;
    localparam int BIT_W            = $clog2(DATA_WIDTH) + 1;

    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_PULSE_WIDTH - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t                state;
    logic                  rx_meta;
    logic                  rx_s;
    logic [CNT_W-1:0]      clk_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_meta          <= 1'b1;
            rx_s             <= 1'b1;
            state            <= S_IDLE;
            clk_cnt          <= '0;
            bit_cnt          <= '0;
            shift_q          <= '0;
            rx_out.data      <= '0;
            rx_out.valid     <= 1'b0;
            rx_out.frame_err <= 1'b0;
            rx_out.overrun   <= 1'b0;
        end else begin
            rx_meta          <= rx_sig;
            rx_s             <= rx_meta;
            rx_out.frame_err <= 1'b0;
            rx_out.overrun   <= 1'b0;

            // NOTE: non-blocking updates let the stop-bit load further down override this
            // handshake clear, so an accept and a new load in the same cycle keep valid high.
            if (rx_out.valid && rx_out.ready) begin
                rx_out.valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state   <= S_START;
                        clk_cnt <= HALF_LOAD;
                    end
                end

                // Re-check the line half a bit later; a short low pulse is ignored silently.
                S_START: begin
                    if (clk_cnt != '0) begin
                        clk_cnt <= clk_cnt - 1'b1;
                    end else if (!rx_s) begin
                        state   <= S_DATA;
                        clk_cnt <= FULL_LOAD;
                        bit_cnt <= '0;
                    end else begin
                        state   <= S_IDLE;
                    end
                end

                S_DATA: begin
                    if (clk_cnt != '0) begin
                        clk_cnt <= clk_cnt - 1'b1;
                    end else begin
                        shift_q <= {rx_s, shift_q[DATA_WIDTH-1:1]};
                        clk_cnt <= FULL_LOAD;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= S_STOP;
                        end
                    end
                end

                S_STOP: begin
                    if (clk_cnt != '0) begin
                        clk_cnt <= clk_cnt - 1'b1;
                    end else if (rx_s) begin
                        if (!rx_out.valid || rx_out.ready) begin
                            rx_out.data  <= shift_q;
                            rx_out.valid <= 1'b1;
                        end else begin
                            rx_out.overrun <= 1'b1;
                        end
                        state <= S_IDLE;
                    end else begin
                        rx_out.frame_err <= 1'b1;
                        state            <= S_BREAK;
                    end
                end

                // A line held low after a bad stop bit must go high before a new start is accepted.
                S_BREAK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // A held word never changes or disappears until the consumer takes it.
    property p_data_held;
        @(posedge clk) disable iff (!rstn)
            (rx_out.valid && !rx_out.ready) |=> (rx_out.valid && $stable(rx_out.data));
    endproperty
    a_data_held: assert property (p_data_held);

    a_pulses_exclusive: assert property (
        @(posedge clk) disable iff (!rstn) !(rx_out.frame_err && rx_out.overrun)
    );
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 10 clk cycles per bit: table-driven frames, hand-written corner cases,
// and randomized line traffic compared against a waveform-sampling reference model.
`timescale 1ns/1ns
module tb_uart_rx;
    localparam int CLK_FREQ  = 1_000_000;
    localparam int BAUD_RATE = 100_000;
    localparam int PW        = CLK_FREQ / BAUD_RATE;
    localparam int HALF      = PW / 2;

    logic clk    = 1'b0;
    logic rstn   = 1'b0;
    logic rx_sig = 1'b1;

    uart_rx_if #(.DATA_WIDTH(8)) rx_out ();

    uart_rx #(
        .DATA_WIDTH(8),
        .BAUD_RATE (BAUD_RATE),
        .CLK_FREQ  (CLK_FREQ)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .rx_sig(rx_sig),
        .rx_out(rx_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output monitor, sampled mid-cycle.
    logic [7:0] got_q[$];
    int fe_cnt = 0;
    int ov_cnt = 0;
    int vcyc   = 0;
    always @(negedge clk) begin
        if (rstn) begin
            if (rx_out.valid) vcyc++;
            if (rx_out.valid && rx_out.ready) got_q.push_back(rx_out.data);
            if (rx_out.frame_err) fe_cnt++;
            if (rx_out.overrun) ov_cnt++;
        end
    end

    // Line history as seen at each clock edge out of reset; index 0 is the first such edge.
    logic line_q[$];
    always @(posedge clk) begin
        if (rstn) line_q.push_back(rx_sig);
    end

    function automatic logic [7:0] got_at(input int idx);
        if (idx >= 0 && idx < got_q.size()) return got_q[idx];
        return 8'hxx;
    endfunction

    task automatic hold(input logic b, input int n);
        rx_sig = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int cpb, input logic stop_val, input int stop_len);
        hold(1'b0, cpb);
        for (int j = 0; j < 8; j++) hold(d[j], cpb);
        hold(stop_val, stop_len);
    endtask

    // Reference: scan the recorded line for a falling level while idle, then sample it at
    // half a bit and every full bit after, exactly as an ideal mid-bit receiver would.
    logic [7:0] exp_q[$];
    task automatic run_model(input int lo, output int n_fe);
        int t;
        int n;
        logic [7:0] w;
        t = lo;
        n = line_q.size();
        n_fe = 0;
        exp_q.delete();
        while (t < n) begin
            if (line_q[t]) begin
                t++;
            end else if (t + HALF + 9 * PW >= n) begin
                t = n;
            end else if (line_q[t + HALF]) begin
                t += HALF + 1;
            end else begin
                for (int j = 0; j < 8; j++) w[j] = line_q[t + HALF + PW * (j + 1)];
                t += HALF + 9 * PW + 1;
                if (line_q[t - 1]) begin
                    exp_q.push_back(w);
                end else begin
                    n_fe++;
                    while (t < n && !line_q[t]) t++;
                    t++;
                end
            end
        end
    endtask

    int got0, fe0, ov0, vc0, lo;

    task automatic snap();
        got0 = got_q.size();
        fe0  = fe_cnt;
        ov0  = ov_cnt;
        vc0  = vcyc;
        lo   = line_q.size();
    endtask

    task automatic model_compare(input string name);
        int nfe;
        hold(1'b1, 150);
        run_model(lo, nfe);
        check({name, " words"}, got_q.size() - got0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) check({name, " word"}, got_at(got0 + i), exp_q[i]);
        check({name, " frame_err"}, fe_cnt - fe0, nfe);
        check({name, " overrun"}, ov_cnt - ov0, 0);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop_val;
        int         stop_len;
        int         exp_words;
        logic [7:0] exp_data;
        int         exp_fe;
    } vec_t;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int   glitch_len[2];
        vecs[0] = '{8'hA5, 1'b1, 10, 1, 8'hA5, 0};
        vecs[1] = '{8'h55, 1'b0, 30, 0, 8'h00, 1};
        vecs[2] = '{8'h81, 1'b1, 10, 1, 8'h81, 0};
        vecs[3] = '{8'h00, 1'b1, 10, 1, 8'h00, 0};
        vecs[4] = '{8'hFF, 1'b1, 10, 1, 8'hFF, 0};
        vecs[5] = '{8'h01, 1'b1, 10, 1, 8'h01, 0};
        glitch_len[0] = 3;
        glitch_len[1] = HALF;

        rx_out.ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset valid", rx_out.valid, 0);
        check("reset data", rx_out.data, 0);
        check("reset frame_err", rx_out.frame_err, 0);
        check("reset overrun", rx_out.overrun, 0);
        rstn = 1'b1;
        hold(1'b1, 20);

        // Single frames at nominal rate, consumer always ready.
        for (int i = 0; i < 6; i++) begin
            snap();
            send_frame(vecs[i].d, PW, vecs[i].stop_val, vecs[i].stop_len);
            hold(1'b1, 150);
            check("table words", got_q.size() - got0, vecs[i].exp_words);
            if (vecs[i].exp_words > 0) check("table data", got_at(got_q.size() - 1), vecs[i].exp_data);
            check("table valid cycles", vcyc - vc0, vecs[i].exp_words);
            check("table frame_err", fe_cnt - fe0, vecs[i].exp_fe);
            check("table overrun", ov_cnt - ov0, 0);
        end

        // Low pulses shorter than half a bit are dropped without error.
        for (int i = 0; i < 2; i++) begin
            snap();
            hold(1'b0, glitch_len[i]);
            hold(1'b1, 60);
            check("glitch valid cycles", vcyc - vc0, 0);
            check("glitch frame_err", fe_cnt - fe0, 0);
        end

        // Overrun: second word arrives while the first is still held.
        rx_out.ready = 1'b0;
        snap();
        send_frame(8'h3C, PW, 1'b1, PW);
        hold(1'b1, 20);
        check("ovr first valid", rx_out.valid, 1);
        check("ovr first data", rx_out.data, 8'h3C);
        send_frame(8'hC3, PW, 1'b1, PW);
        hold(1'b1, 20);
        check("ovr pulse", ov_cnt - ov0, 1);
        check("ovr data held", rx_out.data, 8'h3C);
        check("ovr still valid", rx_out.valid, 1);
        check("ovr nothing taken", got_q.size() - got0, 0);
        rx_out.ready = 1'b1;
        hold(1'b1, 5);
        check("ovr drained", got_q.size() - got0, 1);
        check("ovr drained word", got_at(got0), 8'h3C);
        check("ovr valid low", rx_out.valid, 0);
        hold(1'b1, 100);
        check("ovr no second word", got_q.size() - got0, 1);

        // Accept of the old word on the very edge that loads the new one.
        rx_out.ready = 1'b0;
        snap();
        send_frame(8'h11, PW, 1'b1, PW);
        hold(1'b1, 20);
        fork
            send_frame(8'h22, PW, 1'b1, PW);
            begin
                repeat (HALF + 9 * PW + 2) @(posedge clk);
                #1 rx_out.ready = 1'b1;
                @(posedge clk);
                #1 rx_out.ready = 1'b0;
            end
        join
        hold(1'b1, 20);
        check("same-edge old taken", got_q.size() - got0, 1);
        check("same-edge old word", got_at(got0), 8'h11);
        check("same-edge valid", rx_out.valid, 1);
        check("same-edge new data", rx_out.data, 8'h22);
        check("same-edge overrun", ov_cnt - ov0, 0);
        rx_out.ready = 1'b1;
        hold(1'b1, 5);
        check("same-edge new taken", got_at(got0 + 1), 8'h22);

        // Reset during data bit 4 abandons the frame.
        snap();
        hold(1'b0, PW);
        for (int j = 0; j < 4; j++) hold(((8'h96 >> j) & 8'h01) != 0, PW);
        hold(1'b1, HALF);
        rstn   = 1'b0;
        rx_sig = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midreset valid", rx_out.valid, 0);
        check("midreset data", rx_out.data, 0);
        rstn = 1'b1;
        hold(1'b1, 150);
        check("midreset no word", got_q.size() - got0, 0);
        check("midreset no frame_err", fe_cnt - fe0, 0);
        send_frame(8'h69, PW, 1'b1, PW);
        hold(1'b1, 150);
        check("after reset words", got_q.size() - got0, 1);
        check("after reset word", got_at(got0), 8'h69);

        // Back-to-back frames at off-nominal bit periods.
        snap();
        send_frame(8'h00, PW, 1'b1, PW);
        send_frame(8'hFF, PW, 1'b1, PW);
        send_frame(8'h01, PW, 1'b1, PW);
        model_compare("b2b nominal");
        snap();
        send_frame(8'h00, PW + 1, 1'b1, PW + 1);
        send_frame(8'hFF, PW + 1, 1'b1, PW + 1);
        send_frame(8'h01, PW + 1, 1'b1, PW + 1);
        model_compare("b2b slow");
        snap();
        send_frame(8'h00, PW - 1, 1'b1, PW - 1);
        send_frame(8'hFF, PW - 1, 1'b1, PW - 1);
        send_frame(8'h01, PW - 1, 1'b1, PW - 1);
        model_compare("b2b fast");

        // Random traffic: frames, bad stop bits, glitches, variable gaps.
        for (int s = 0; s < 4; s++) begin
            snap();
            for (int e = 0; e < 6; e++) begin
                int kind;
                int cpb;
                kind = int'($urandom_range(0, 9));
                cpb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(PW - 1, PW + 1)) : PW;
                if (kind == 0) begin
                    hold(1'b0, int'($urandom_range(1, 8)));
                end else if (kind == 1) begin
                    send_frame(8'($urandom), cpb, 1'b0, int'($urandom_range(10, 30)));
                end else begin
                    send_frame(8'($urandom), cpb, 1'b1, cpb);
                end
                hold(1'b1, int'($urandom_range(0, 12)));
            end
            model_compare("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
